flipper_trig_arbiter: RTL and testbench
=======================================

FLIPPER_TRIG_ARBITER -- requirements
Module: flipper_trig_arbiter

Interface
REQ-001 The block SHALL have parameter XC_L, default 185, meaning left flipper pivot X.
REQ-002 The block SHALL have parameter XC_R, default 455, meaning right flipper pivot X.
REQ-003 The block SHALL have parameter YC, default 400, meaning the shared pivot Y.
REQ-004 The block SHALL have parameter R, default 80, meaning flipper length in pixels.
REQ-005 The block SHALL have parameters RST_XL, RST_XR and RST_Y, defaults 234, 406 and 463, meaning the rest-position tip coordinates (alpha 52).
REQ-006 clk  in  1  sole clock; all state updates on its rising edge.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 req_l  in  1  one-cycle request pulse from the left flipper.
REQ-009 alpha_l  in  7  left angle in degrees, valid with req_l.
REQ-010 req_r  in  1  one-cycle request pulse from the right flipper.
REQ-011 alpha_r  in  7  right angle in degrees, valid with req_r.
REQ-012 rom_addr  out  7  angle index to the shared sin/cos ROM.
REQ-013 rom_cos  in  11  cos(rom_addr)*1024, valid one clock after rom_addr is registered.
REQ-014 rom_sin  in  11  sin(rom_addr)*1024, with the same timing as rom_cos.
REQ-015 X_l and Y_l  out  11 each  left tip coordinates, registered.
REQ-016 X_r and Y_r  out  11 each  right tip coordinates, registered.
REQ-017 done_l and done_r  out  1 each  one-cycle pulse when the matching coordinates update.
REQ-018 busy  out  1  high whenever the FSM is not IDLE.

Function
REQ-019 Per-requester pending flag and 7-bit alpha register: a req pulse sets the flag and latches alpha, clamped to 90 if above 90.
REQ-020 A req pulse while that requester is already pending SHALL overwrite the latched alpha (latest wins); the requester is serviced only once.
REQ-021 FSM states SHALL be IDLE, READ, CALC and WRITE, advancing one state per clock with no stalls.
REQ-022 In IDLE, if any flag is pending, the FSM SHALL grant one requester, register rom_addr from its alpha, clear its flag and go to READ.
REQ-023 If a req pulse for the granted requester coincides with its grant, the flag SHALL remain set with the new alpha.
REQ-024 Arbitration SHALL be round-robin: on simultaneous pending, grant the requester not served last.
REQ-025 After reset, the left requester SHALL have priority.
REQ-026 READ SHALL go to CALC, where rom_cos and rom_sin are valid.
REQ-027 CALC SHALL register pc = R*rom_cos and ps = R*rom_sin as 17-bit unsigned products, then go to WRITE.
REQ-028 In WRITE, the granted side's outputs SHALL update: X_l = XC_L + (pc>>10), X_r = XC_R - (pc>>10), Y = YC + (ps>>10).
REQ-029 Shifts SHALL truncate, and results SHALL be taken modulo 2^11 with no saturation.
REQ-030 WRITE SHALL pulse the granted side's done for exactly one cycle and return to IDLE; the other side's outputs hold.
REQ-031 Uncontended latency: req sampled at edge k -> pending at edge k -> READ at k+1 -> CALC at k+2 -> WRITE at k+3 -> done high during cycle after edge k+3, outputs valid same cycle.
REQ-032 Back-to-back grants: a requester pending while the FSM is in WRITE SHALL be granted in the following IDLE cycle, giving a 4-cycle service period.
REQ-033 rom_addr SHALL hold its value outside IDLE grants.

Reset
REQ-034 When reset is asserted, FSM = IDLE, both flags = 0, rom_addr = 0, done_l = done_r = 0, busy = 0, last-served = right.
REQ-035 When reset is asserted, X_l = RST_XL, X_r = RST_XR, Y_l = Y_r = RST_Y.
REQ-036 Reset asserted mid-operation SHALL abort the transaction immediately with no done pulse, and outputs SHALL return to reset values.

Verification
REQ-037 req_r with alpha_r = 0 (bench ROM cos = 1024, sin = 0) -> done_r 4 edges later, X_r = 375, Y_r = 400; left outputs unchanged.
REQ-038 req_l with alpha_l = 90 (cos = 0, sin = 1024) -> X_l = 185, Y_l = 480, done_l single cycle.
REQ-039 req_l and req_r in the same cycle after reset -> left serviced first, right done 4 cycles after left done.
REQ-040 req_r with alpha = 30, then req_r with alpha = 52 before grant -> one done_r only, X_r = 406, Y_r = 463.
REQ-041 alpha_l = 120 -> clamped, rom_addr = 90, X_l = 185, Y_l = 480.
REQ-042 Reset asserted during CALC -> no done pulse, outputs = 234/406/463, busy = 0, next request serviced normally.

Source files
------------

// File: rtl/flipper_trig_arbiter.sv
// flipper_trig_arbiter
//   Shares one sin/cos ROM between the left and right flipper tip
//   calculators. Each side posts a one-cycle request carrying its angle.
//   A round-robin arbiter grants one side, reads cos/sin for its angle and
//   turns them into tip coordinates around that side's pivot.
//
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   req_l/alpha_l         left request pulse and angle in degrees (0..127, clamped to 90)
//   req_r/alpha_r         right request pulse and angle in degrees
//   rom_addr              angle index to the shared ROM (registered)
//   rom_cos/rom_sin       ROM data *1024, valid one clock after rom_addr
//   X_l/Y_l, X_r/Y_r      registered tip coordinates
//   done_l/done_r         one-cycle pulse when that side's coordinates update
//   busy                  transaction in flight (FSM not idle)
module flipper_trig_arbiter #(
  parameter int XC_L   = 185,
  parameter int XC_R   = 455,
  parameter int YC     = 400,
  parameter int R      = 80,
  parameter int RST_XL = 234,
  parameter int RST_XR = 406,
  parameter int RST_Y  = 463
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_l,
  input  logic [6:0]  alpha_l,
  input  logic        req_r,
  input  logic [6:0]  alpha_r,
  output logic [6:0]  rom_addr,
  input  logic [10:0] rom_cos,
  input  logic [10:0] rom_sin,
  output logic [10:0] X_l,
  output logic [10:0] Y_l,
  output logic [10:0] X_r,
  output logic [10:0] Y_r,
  output logic        done_l,
  output logic        done_r,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, READ, CALC, WRITE} state_t;

  localparam logic [16:0] R17    = 17'(R);
  localparam logic [10:0] XCL11  = 11'(XC_L);
  localparam logic [10:0] XCR11  = 11'(XC_R);
  localparam logic [10:0] YC11   = 11'(YC);
  localparam logic [10:0] RSTXL  = 11'(RST_XL);
  localparam logic [10:0] RSTXR  = 11'(RST_XR);
  localparam logic [10:0] RSTY   = 11'(RST_Y);
  localparam logic [6:0]  AMAX   = 7'd90;

  state_t      state_q, state_d;
  logic        pend_l_q, pend_l_d, pend_r_q, pend_r_d;
  logic [6:0]  alpha_l_q, alpha_l_d, alpha_r_q, alpha_r_d;
  logic        last_r_q, last_r_d;   // 1: right was served last
  logic        gnt_r_q, gnt_r_d;     // side owning the current transaction
  logic [6:0]  rom_addr_q, rom_addr_d;
  logic [10:0] xl_q, xl_d, yl_q, yl_d, xr_q, xr_d, yr_q, yr_d;
  logic        done_l_q, done_l_d, done_r_q, done_r_d;

  logic [6:0]  alpha_l_c, alpha_r_c;
  logic        sel_r;
  logic [16:0] pc, ps;
  logic [10:0] pc_sh, ps_sh;

  assign alpha_l_c = (alpha_l > AMAX) ? AMAX : alpha_l;
  assign alpha_r_c = (alpha_r > AMAX) ? AMAX : alpha_r;

  // On a tie the side that was not served last wins; reset leaves
  // "right" as last so the left side goes first.
  assign sel_r = pend_r_q && (!pend_l_q || !last_r_q);

  // The 17-bit products are captured straight into the coordinate
  // registers at the CALC->WRITE edge, so the coordinates and the done
  // pulse appear together in the WRITE cycle.
  assign pc    = R17 * {6'd0, rom_cos};
  assign ps    = R17 * {6'd0, rom_sin};
  assign pc_sh = 11'(pc >> 10);
  assign ps_sh = 11'(ps >> 10);

  always_comb begin
    state_d    = state_q;
    pend_l_d   = pend_l_q;
    pend_r_d   = pend_r_q;
    alpha_l_d  = alpha_l_q;
    alpha_r_d  = alpha_r_q;
    last_r_d   = last_r_q;
    gnt_r_d    = gnt_r_q;
    rom_addr_d = rom_addr_q;
    xl_d       = xl_q;
    yl_d       = yl_q;
    xr_d       = xr_q;
    yr_d       = yr_q;
    done_l_d   = 1'b0;
    done_r_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (pend_l_q || pend_r_q) begin
          state_d    = READ;
          gnt_r_d    = sel_r;
          last_r_d   = sel_r;
          rom_addr_d = sel_r ? alpha_r_q : alpha_l_q;
          if (sel_r) pend_r_d = 1'b0;
          else       pend_l_d = 1'b0;
        end
      end
      READ: state_d = CALC;
      CALC: begin
        state_d = WRITE;
        if (gnt_r_q) begin
          xr_d     = XCR11 - pc_sh;
          yr_d     = YC11 + ps_sh;
          done_r_d = 1'b1;
        end else begin
          xl_d     = XCL11 + pc_sh;
          yl_d     = YC11 + ps_sh;
          done_l_d = 1'b1;
        end
      end
      WRITE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A new pulse always wins over the grant's clear, so a request
    // landing on its own grant stays pending with the fresh angle.
    if (req_l) begin
      pend_l_d  = 1'b1;
      alpha_l_d = alpha_l_c;
    end
    if (req_r) begin
      pend_r_d  = 1'b1;
      alpha_r_d = alpha_r_c;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      pend_l_q   <= 1'b0;
      pend_r_q   <= 1'b0;
      alpha_l_q  <= 7'd0;
      alpha_r_q  <= 7'd0;
      last_r_q   <= 1'b1;
      gnt_r_q    <= 1'b0;
      rom_addr_q <= 7'd0;
      xl_q       <= RSTXL;
      yl_q       <= RSTY;
      xr_q       <= RSTXR;
      yr_q       <= RSTY;
      done_l_q   <= 1'b0;
      done_r_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_l_q   <= pend_l_d;
      pend_r_q   <= pend_r_d;
      alpha_l_q  <= alpha_l_d;
      alpha_r_q  <= alpha_r_d;
      last_r_q   <= last_r_d;
      gnt_r_q    <= gnt_r_d;
      rom_addr_q <= rom_addr_d;
      xl_q       <= xl_d;
      yl_q       <= yl_d;
      xr_q       <= xr_d;
      yr_q       <= yr_d;
      done_l_q   <= done_l_d;
      done_r_q   <= done_r_d;
    end
  end

  assign rom_addr = rom_addr_q;
  assign X_l      = xl_q;
  assign Y_l      = yl_q;
  assign X_r      = xr_q;
  assign Y_r      = yr_q;
  assign done_l   = done_l_q;
  assign done_r   = done_r_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_flipper_trig_arbiter.sv
// Bench for flipper_trig_arbiter: directed scenarios with literal
// expectations, then random requests/resets compared every cycle against
// an event-scheduled model (grant edge g -> coordinates/done after g+2,
// next grant no earlier than g+4).
module tb_flipper_trig_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_l = 1'b0, req_r = 1'b0;
  logic [6:0]  alpha_l = 7'd0, alpha_r = 7'd0;
  logic [10:0] rom_cos = 11'd0, rom_sin = 11'd0;
  wire  [6:0]  rom_addr;
  wire  [10:0] X_l, Y_l, X_r, Y_r;
  wire         done_l, done_r, busy;

  flipper_trig_arbiter dut (
    .clk(clk), .reset(reset),
    .req_l(req_l), .alpha_l(alpha_l), .req_r(req_r), .alpha_r(alpha_r),
    .rom_addr(rom_addr), .rom_cos(rom_cos), .rom_sin(rom_sin),
    .X_l(X_l), .Y_l(Y_l), .X_r(X_r), .Y_r(Y_r),
    .done_l(done_l), .done_r(done_r), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ROM contents: rounded cos/sin * 1024 for 0..90 degrees
  int cos_tab[128];
  int sin_tab[128];
  initial begin
    for (int i = 0; i < 128; i++) begin
      if (i <= 90) begin
        cos_tab[i] = int'($cos(i * 3.14159265358979 / 180.0) * 1024.0);
        sin_tab[i] = int'($sin(i * 3.14159265358979 / 180.0) * 1024.0);
      end else begin
        cos_tab[i] = 0;
        sin_tab[i] = 0;
      end
    end
  end

  always @(posedge clk) begin
    rom_cos <= 11'(cos_tab[rom_addr]);
    rom_sin <= 11'(sin_tab[rom_addr]);
  end

  // ---------------- behavioural model ----------------
  int n = 0, free_at = 0;
  bit pl = 0, pr = 0, last_r = 1;
  int al = 0, ar = 0;
  bit tx_v = 0, tx_r = 0;
  int tx_edge = 0, tx_x = 0, tx_y = 0;
  int e_xl = 234, e_yl = 463, e_xr = 406, e_yr = 463, e_rom = 0;
  bit e_dl = 0, e_dr = 0, e_busy = 0;
  bit g_r;
  int g_a, g_pc, g_ps;

  function automatic int clampa(input int a);
    return (a > 90) ? 90 : a;
  endfunction

  always @(posedge clk) begin
    n++;
    if (reset) begin
      pl = 0; pr = 0; last_r = 1; tx_v = 0; free_at = 0;
      e_xl = 234; e_yl = 463; e_xr = 406; e_yr = 463; e_rom = 0;
      e_dl = 0; e_dr = 0; e_busy = 0;
    end else begin
      e_dl = 0; e_dr = 0;
      if (tx_v && n == tx_edge) begin
        if (tx_r) begin e_xr = tx_x; e_yr = tx_y; e_dr = 1; end
        else      begin e_xl = tx_x; e_yl = tx_y; e_dl = 1; end
        tx_v = 0;
      end
      if (n >= free_at && (pl || pr)) begin
        g_r  = pr && (!pl || !last_r);
        g_a  = g_r ? ar : al;
        e_rom = g_a;
        g_pc = 80 * cos_tab[g_a];
        g_ps = 80 * sin_tab[g_a];
        tx_x = g_r ? ((455 - g_pc / 1024) & 2047) : ((185 + g_pc / 1024) & 2047);
        tx_y = (400 + g_ps / 1024) & 2047;
        tx_r = g_r; tx_v = 1; tx_edge = n + 2; free_at = n + 4; last_r = g_r;
        if (g_r) pr = 0; else pl = 0;
      end
      if (req_l) begin pl = 1; al = clampa(int'(alpha_l)); end
      if (req_r) begin pr = 1; ar = clampa(int'(alpha_r)); end
      e_busy = (n < free_at - 1);
    end
  end

  always @(negedge clk) begin
    if (chk_en && !reset) begin
      chk("m_X_l", X_l, e_xl);
      chk("m_Y_l", Y_l, e_yl);
      chk("m_X_r", X_r, e_xr);
      chk("m_Y_r", Y_r, e_yr);
      chk("m_done_l", done_l, e_dl);
      chk("m_done_r", done_r, e_dr);
      chk("m_busy", busy, e_busy);
      chk("m_rom_addr", rom_addr, e_rom);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rst_pulse();
    reset = 1'b1; req_l = 1'b0; req_r = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  int cnt;

  initial begin
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_X_l", X_l, 234);
    chk("rst_Y_l", Y_l, 463);
    chk("rst_X_r", X_r, 406);
    chk("rst_Y_r", Y_r, 463);
    chk("rst_rom", rom_addr, 0);
    chk("rst_done", {done_l, done_r}, 0);
    reset = 1'b0;
    chk_en = 1'b1;

    // right, alpha 0
    req_r = 1; alpha_r = 7'd0; tick(); req_r = 0;
    tick(); tick();
    chk("r0_early_done", done_r, 0);
    tick();
    chk("r0_done", done_r, 1);
    chk("r0_X_r", X_r, 375);
    chk("r0_Y_r", Y_r, 400);
    chk("r0_X_l_hold", X_l, 234);
    chk("r0_Y_l_hold", Y_l, 463);
    tick();
    chk("r0_done_once", done_r, 0);

    // left, alpha 90
    req_l = 1; alpha_l = 7'd90; tick(); req_l = 0;
    tick(); tick(); tick();
    chk("l90_done", done_l, 1);
    chk("l90_X_l", X_l, 185);
    chk("l90_Y_l", Y_l, 480);
    tick();
    chk("l90_done_once", done_l, 0);

    // simultaneous after reset: left first, right 4 cycles later
    rst_pulse();
    req_l = 1; alpha_l = 7'd0; req_r = 1; alpha_r = 7'd0; tick();
    req_l = 0; req_r = 0;
    tick(); tick(); tick();
    chk("both_done_l", done_l, 1);
    chk("both_done_r_not_yet", done_r, 0);
    chk("both_X_l", X_l, 265);
    tick(); tick(); tick(); tick();
    chk("both_done_r", done_r, 1);
    chk("both_X_r", X_r, 375);
    tick();

    // latest angle wins while waiting behind the left side
    req_l = 1; alpha_l = 7'd0; tick(); req_l = 0;
    req_r = 1; alpha_r = 7'd30; tick();
    alpha_r = 7'd52; tick(); req_r = 0;
    cnt = 0;
    repeat (12) begin tick(); if (done_r) cnt++; end
    chk("lw_done_count", cnt, 1);
    chk("lw_X_r", X_r, 406);
    chk("lw_Y_r", Y_r, 463);

    // clamp
    req_l = 1; alpha_l = 7'd120; tick(); req_l = 0;
    tick();
    chk("clamp_rom", rom_addr, 90);
    tick(); tick();
    chk("clamp_done", done_l, 1);
    chk("clamp_X_l", X_l, 185);
    chk("clamp_Y_l", Y_l, 480);
    tick();

    // reset during CALC
    req_l = 1; alpha_l = 7'd0; tick(); req_l = 0;
    tick(); tick();
    chk("abort_busy_before", busy, 1);
    reset = 1; #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", {done_l, done_r}, 0);
    chk("abort_X_l", X_l, 234);
    chk("abort_Y_l", Y_l, 463);
    chk("abort_X_r", X_r, 406);
    chk("abort_Y_r", Y_r, 463);
    chk("abort_rom", rom_addr, 0);
    tick(); reset = 0;
    cnt = 0;
    repeat (4) begin tick(); if (done_l || done_r) cnt++; end
    chk("abort_no_done", cnt, 0);
    req_r = 1; alpha_r = 7'd0; tick(); req_r = 0;
    tick(); tick(); tick();
    chk("after_abort_done", done_r, 1);
    chk("after_abort_X_r", X_r, 375);
    tick();

    // random traffic
    repeat (800) begin
      if ($urandom_range(0, 199) == 0) begin
        rst_pulse();
      end else begin
        req_l   = ($urandom_range(0, 3) == 0);
        alpha_l = 7'($urandom_range(0, 127));
        req_r   = ($urandom_range(0, 3) == 0);
        alpha_r = 7'($urandom_range(0, 127));
        tick();
      end
    end
    req_l = 0; req_r = 0;
    repeat (12) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
